// File: rtl/serial_tx_16_if.sv
// rtl/serial_tx_16_if.sv - Word-in / bit-out signal bundle for serial_tx_16
interface serial_tx_16_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             ser_out;
    logic             ser_valid;
    logic             ser_first;
    logic             ser_last;
    logic             busy;

    modport master (
        output in_valid, in_data,
        input  in_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, ser_out, ser_valid, ser_first, ser_last, busy
    );
endinterface

// File: rtl/serial_tx_16.sv
// rtl/serial_tx_16.sv - Parallel-to-serial transmitter with one-word holding buffer
// Optional even-parity trailer bit enabled by defining TX_PARITY_EN.
module serial_tx_16 #(
    parameter int WIDTH     = 16,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    serial_tx_16_if.slave   tx
);

`ifdef TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
`else
    localparam int FRAME = WIDTH;
`endif
    localparam int CNT_W = $clog2(FRAME);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ser_out_q, ser_out_d;
    logic               ser_valid_q, ser_valid_d;
    logic               ser_first_q, ser_first_d;
    logic               ser_last_q, ser_last_d;
    logic               xfer;
    logic               load;
    logic [WIDTH-1:0]   load_word;
    logic               data_bit;
`ifdef TX_PARITY_EN
    logic               par_q, par_d;
`endif

    assign tx.in_ready  = !hold_full_q;
    assign tx.busy      = (state_q == SHIFT) || hold_full_q;
    assign tx.ser_out   = ser_out_q;
    assign tx.ser_valid = ser_valid_q;
    assign tx.ser_first = ser_first_q;
    assign tx.ser_last  = ser_last_q;

    assign xfer = tx.in_valid && !hold_full_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs are derived from next-state values so they are registered yet
    // describe the bit that is on the line during the following cycle.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        cnt_d       = cnt_q;
        load        = 1'b0;
        load_word   = '0;

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d   = SHIFT;
                    load      = 1'b1;
                    load_word = tx.in_data;
                end
            end
            SHIFT: begin
                if (cnt_q != LAST_CNT) begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    shift_d = MSB_FIRST ? {shift_q[WIDTH-2:0], 1'b0}
                                        : {1'b0, shift_q[WIDTH-1:1]};
                    if (xfer) begin
                        hold_d      = tx.in_data;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    load        = 1'b1;
                    load_word   = hold_q;
                    hold_full_d = 1'b0;
                end else if (xfer) begin
                    load      = 1'b1;
                    load_word = tx.in_data;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
        endcase

        if (load) begin
            shift_d = load_word;
            cnt_d   = '0;
        end

`ifdef TX_PARITY_EN
        par_d = par_q;
        if (load) begin
            par_d = ^load_word;
        end
        data_bit = (cnt_d == CNT_W'(WIDTH)) ? par_d
                 : (MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0]);
`else
        data_bit = MSB_FIRST ? shift_d[WIDTH-1] : shift_d[0];
`endif

        ser_valid_d = (state_d == SHIFT);
        ser_out_d   = ser_valid_d && data_bit;
        ser_first_d = ser_valid_d && (cnt_d == '0);
        ser_last_d  = ser_valid_d && (cnt_d == LAST_CNT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            cnt_q       <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            ser_first_q <= 1'b0;
            ser_last_q  <= 1'b0;
        end else begin
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            cnt_q       <= cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            ser_first_q <= ser_first_d;
            ser_last_q  <= ser_last_d;
        end
    end

`ifdef TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end
`endif

endmodule

// File: tb/tb_serial_tx_16.sv
// tb/tb_serial_tx_16.sv - Self-checking bench for serial_tx_16 (stream model plus literal checks)
module tb_serial_tx_16;

    localparam int WIDTH = 16;
`ifdef TX_PARITY_EN
    localparam int FRAME = WIDTH + 1;
    localparam logic [63:0] EXP_SINGLE    = 64'h0000_0000_0001_4B86;
    localparam logic [63:0] EXP_SINGLE_F  = 64'h0000_0000_0001_0000;
    localparam logic [63:0] EXP_STREAM    = {13'd0, 16'hFFFF, 1'b0, 16'h0001, 1'b1, 16'h1234, 1'b1};
    localparam logic [63:0] EXP_STREAM_L  = 64'h0000_0004_0002_0001;
    localparam logic [63:0] EXP_STREAM_F  = 64'h0004_0002_0001_0000;
`else
    localparam int FRAME = WIDTH;
    localparam logic [63:0] EXP_SINGLE    = 64'h0000_0000_0000_A5C3;
    localparam logic [63:0] EXP_SINGLE_F  = 64'h0000_0000_0000_8000;
    localparam logic [63:0] EXP_STREAM    = 64'h0000_FFFF_0001_1234;
    localparam logic [63:0] EXP_STREAM_L  = 64'h0000_0001_0001_0001;
    localparam logic [63:0] EXP_STREAM_F  = 64'h0000_8000_8000_8000;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_tx_16_if #(.WIDTH(WIDTH)) tx ();

    serial_tx_16 #(.WIDTH(WIDTH), .MSB_FIRST(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .tx  (tx)
    );

    // Model: words still owed to the line, oldest first; head is being sent.
    logic [WIDTH-1:0] m_q[$];
    int  m_pos    = 0;
    bit  m_active = 0;
    bit  m_init   = 0;
    bit  m_acc    = 0;
    bit  m_xfer, m_done;

    function automatic logic fbit(input logic [WIDTH-1:0] w, input int p);
        if (p >= WIDTH) return ^w;
        return w[WIDTH-1-p];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_pos    = 0;
            m_active = 0;
            m_init   = 1;
            m_acc    = 0;
        end else begin
            m_xfer = tx.in_valid && (m_q.size() < 2);
            m_done = m_active && (m_pos == FRAME - 1);
            if (m_done) void'(m_q.pop_front());
            else if (m_active) m_pos++;
            if (m_xfer) m_q.push_back(tx.in_data);
            if (m_done || !m_active) begin
                m_pos    = 0;
                m_active = (m_q.size() > 0);
            end
            m_acc = m_xfer;
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int req_id = 0;
    int done_id = 0;
    int req_kind = 0;
    logic [63:0] cap = '0, firsts = '0, lasts = '0;
    int cap_n = 0, first_cyc = 0, last_cyc = 0;
    logic e_out, e_first, e_last, e_busy, e_ready;

    task automatic lit(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        cyc++;
        if (m_init) begin
            e_out   = m_active ? fbit(m_q[0], m_pos) : 1'b0;
            e_first = m_active && (m_pos == 0);
            e_last  = m_active && (m_pos == FRAME - 1);
            e_busy  = (m_q.size() > 0);
            e_ready = (m_q.size() < 2);
            n_cmp++;
            if (tx.ser_valid !== m_active || (m_active && tx.ser_out !== e_out) ||
                tx.ser_first !== e_first || tx.ser_last !== e_last ||
                tx.busy !== e_busy || tx.in_ready !== e_ready) begin
                n_err++;
                $display("FAIL cycle_%0d: got valid/out/first/last/busy/ready=%b%b%b%b%b%b want %b%b%b%b%b%b",
                         cyc, tx.ser_valid, tx.ser_out, tx.ser_first, tx.ser_last, tx.busy, tx.in_ready,
                         m_active, e_out, e_first, e_last, e_busy, e_ready);
            end
            if (tx.ser_valid === 1'b1) begin
                cap    = {cap[62:0], tx.ser_out};
                firsts = {firsts[62:0], tx.ser_first};
                lasts  = {lasts[62:0], tx.ser_last};
                if (cap_n == 0) first_cyc = cyc;
                last_cyc = cyc;
                cap_n++;
            end
        end
        if (req_id != done_id) begin
            case (req_kind)
                0: begin
                    lit("idle_valid", 64'(tx.ser_valid), 64'd0);
                    lit("idle_ready", 64'(tx.in_ready), 64'd1);
                    lit("idle_busy", 64'(tx.busy), 64'd0);
                    lit("idle_bits", 64'(cap_n), 64'd0);
                end
                1: begin
                    lit("single_bits", cap, EXP_SINGLE);
                    lit("single_len", 64'(cap_n), 64'(FRAME));
                    lit("single_first", firsts, EXP_SINGLE_F);
                    lit("single_last", lasts, 64'd1);
                end
                2: begin
                    lit("stream_bits", cap, EXP_STREAM);
                    lit("stream_len", 64'(cap_n), 64'(3 * FRAME));
                    lit("stream_span", 64'(last_cyc - first_cyc + 1), 64'(3 * FRAME));
                    lit("stream_last", lasts, EXP_STREAM_L);
                    lit("stream_first", firsts, EXP_STREAM_F);
                end
                3: begin
                    lit("rst_bits", cap, 64'h0000_0000_0000_00BE);
                    lit("rst_len", 64'(cap_n), 64'd8);
                    lit("rst_idle_valid", 64'(tx.ser_valid), 64'd0);
                end
                4: begin
                    lit("par7_bits", cap, 64'h0000_0000_0000_000F);
                    lit("par7_len", 64'(cap_n), 64'd17);
                    lit("par7_last", lasts, 64'd1);
                end
                5: begin
                    lit("par3_bits", cap, 64'h0000_0000_0000_0006);
                    lit("par3_len", 64'(cap_n), 64'd17);
                end
                default: begin
                    lit("rstnext_valid", 64'(tx.ser_valid), 64'd0);
                    lit("rstnext_busy", 64'(tx.busy), 64'd0);
                    lit("rstnext_ready", 64'(tx.in_ready), 64'd1);
                end
            endcase
            if (req_kind != 6) begin
                cap = '0; firsts = '0; lasts = '0; cap_n = 0;
            end
            done_id = req_id;
        end
    end

    task automatic post(input int k);
        @(posedge clk);
        #1;
        req_kind = k;
        req_id++;
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] w);
        tx.in_valid = 1'b1;
        tx.in_data  = w;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (m_acc) return;
        end
        $display("FAIL send_timeout: word %h not accepted within 200 cycles", w);
        $fatal(1);
    endtask

    initial begin
        tx.in_valid = 1'b0;
        tx.in_data  = '0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        post(0);

        send(16'hA5C3);
        tx.in_valid = 1'b0;
        repeat (FRAME + 6) @(negedge clk);
        post(1);

        send(16'hFFFF);
        send(16'h0001);
        send(16'h1234);
        tx.in_valid = 1'b0;
        repeat (3 * FRAME + 6) @(negedge clk);
        post(2);

        send(16'hBEEF);
        send(16'h1234);
        tx.in_valid = 1'b0;
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        req_kind = 6;
        req_id++;
        @(negedge clk);
        repeat (2 * FRAME) @(negedge clk);
        post(3);

`ifdef TX_PARITY_EN
        send(16'h0007);
        tx.in_valid = 1'b0;
        repeat (FRAME + 6) @(negedge clk);
        post(4);
        send(16'h0003);
        tx.in_valid = 1'b0;
        repeat (FRAME + 6) @(negedge clk);
        post(5);
`endif

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
